// File: rtl/writeback_stage.sv
// writeback_stage: final RV32 pipeline stage feeding the register file.
// Accepts MEM results over valid/ready and formats load data. One entry is
// held in the WB register, which drives the regfile write port and the WB
// forwarding bus. The regfile writes on negedge, so an entry loaded at
// posedge N is written at negedge N.
module writeback_stage #(
  parameter int DATA_WIDTH        = 32,
  parameter int ADDRESS_BIT_WIDTH = 5
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         en,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ADDRESS_BIT_WIDTH-1:0] in_rd,
  input  logic [DATA_WIDTH-1:0]        in_result,
  input  logic                         in_load,
  input  logic [2:0]                   in_funct3,
  input  logic [1:0]                   in_addr_lo,
  input  logic                         in_reg_write,
  output logic [ADDRESS_BIT_WIDTH-1:0] A3,
  output logic [DATA_WIDTH-1:0]        WD3,
  output logic                         WE3,
  output logic                         fwd_valid,
  output logic [ADDRESS_BIT_WIDTH-1:0] fwd_rd,
  output logic [DATA_WIDTH-1:0]        fwd_data,
  output logic                         load_err,
  output logic [31:0]                  retire_count
);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // A load is illegal when misaligned for its width or when funct3 is not a load width.
  function automatic logic load_illegal(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic bad;
    case (funct3)
      F3_LB, F3_LBU: bad = 1'b0;
      F3_LH, F3_LHU: bad = addr_lo[0];
      F3_LW:         bad = (addr_lo != 2'b00);
      default:       bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Extract the addressed byte/half from the aligned load word and extend it.
  function automatic logic [DATA_WIDTH-1:0] load_format(input logic [DATA_WIDTH-1:0] raw,
                                                        input logic [2:0]            funct3,
                                                        input logic [1:0]            addr_lo);
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] res;
    shifted = raw >> {addr_lo, 3'b000};
    case (funct3)
      F3_LB:   res = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      F3_LBU:  res = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      F3_LH:   res = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      F3_LHU:  res = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      F3_LW:   res = shifted;
      default: res = raw;
    endcase
    return res;
  endfunction

  logic                         wb_valid_r;
  logic [ADDRESS_BIT_WIDTH-1:0] wb_rd_r;
  logic [DATA_WIDTH-1:0]        wb_data_r;
  logic                         wb_we_r;
  logic                         load_err_r;
  logic [31:0]                  retire_count_r;

  logic                         accept_s;
  logic                         retire_s;
  logic                         next_err_s;
  logic [DATA_WIDTH-1:0]        next_data_s;
  logic                         write_s;

  // Handshake and formatting of the incoming entry.
  always_comb begin
    in_ready    = en | ~wb_valid_r;
    accept_s    = in_valid & in_ready;
    retire_s    = wb_valid_r & en;
    next_err_s  = 1'b0;
    next_data_s = in_result;
    if (in_load) begin
      next_err_s = load_illegal(in_funct3, in_addr_lo);
      if (next_err_s) begin
        next_data_s = in_result;
      end else begin
        next_data_s = load_format(in_result, in_funct3, in_addr_lo);
      end
    end else begin
      next_err_s  = 1'b0;
      next_data_s = in_result;
    end
  end

  // WB entry register: accept wins over retire, otherwise hold.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb_valid_r <= 1'b0;
      wb_rd_r    <= {ADDRESS_BIT_WIDTH{1'b0}};
      wb_data_r  <= {DATA_WIDTH{1'b0}};
      wb_we_r    <= 1'b0;
      load_err_r <= 1'b0;
    end else if (accept_s) begin
      wb_valid_r <= 1'b1;
      wb_rd_r    <= in_rd;
      wb_data_r  <= next_data_s;
      wb_we_r    <= in_reg_write;
      load_err_r <= next_err_s;
    end else if (retire_s) begin
      wb_valid_r <= 1'b0;
      load_err_r <= 1'b0;
    end
  end

  // Retired-entry counter, wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      retire_count_r <= 32'd0;
    end else if (retire_s) begin
      retire_count_r <= retire_count_r + 32'd1;
    end
  end

  // Regfile port and forwarding bus, derived only from the WB register.
  always_comb begin
    write_s      = wb_valid_r & wb_we_r & (wb_rd_r != {ADDRESS_BIT_WIDTH{1'b0}}) & ~load_err_r;
    A3           = wb_rd_r;
    WD3          = wb_data_r;
    WE3          = write_s;
    fwd_valid    = write_s;
    fwd_rd       = wb_rd_r;
    fwd_data     = wb_data_r;
    load_err     = wb_valid_r & load_err_r;
    retire_count = retire_count_r;
  end

endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed and randomized checks of writeback_stage
// against a transaction-level reference model.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_result;
  logic        in_load;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic        in_reg_write;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic        WE3;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        load_err;
  logic [31:0] retire_count;

  int checks = 0;
  int failures = 0;

  // Reference model: the single held entry and the retire tally.
  bit          m_valid;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;
  bit          m_we;
  bit          m_err;
  logic [31:0] m_count;

  writeback_stage dut (
    .clk(clk), .rstn(rstn), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_result(in_result), .in_load(in_load), .in_funct3(in_funct3),
    .in_addr_lo(in_addr_lo), .in_reg_write(in_reg_write), .A3(A3), .WD3(WD3), .WE3(WE3),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .load_err(load_err),
    .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  function automatic void ref_load(input logic [31:0] raw, input logic [2:0] f3, input logic [1:0] lo,
                                   output logic [31:0] data, output bit err);
    int unsigned d, b, h;
    err = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) ||
          (((f3 == 3'd1) || (f3 == 3'd5)) && (lo % 2 == 1)) ||
          ((f3 == 3'd2) && (lo != 2'd0));
    d = raw / (32'd1 << (8 * lo));
    b = d % 256;
    h = d % 65536;
    if (err)             data = raw;
    else if (f3 == 3'd0) data = (b >= 128) ? b + 32'hFFFF_FF00 : b;
    else if (f3 == 3'd4) data = b;
    else if (f3 == 3'd1) data = (h >= 32768) ? h + 32'hFFFF_0000 : h;
    else if (f3 == 3'd5) data = h;
    else                 data = d;
  endfunction

  function automatic bit exp_we();
    return m_valid && m_we && (m_rd != 5'd0) && !m_err;
  endfunction

  function automatic bit exp_err();
    return m_valid && m_err;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_rd = 5'd0; m_wd = 32'd0; m_we = 1'b0; m_err = 1'b0; m_count = 32'd0;
  endtask

  // One clock: advance the model with the inputs present at the edge, then settle.
  task automatic tick();
    bit acc, ret, e;
    logic [31:0] d;
    @(posedge clk);
    acc = in_valid && (en || !m_valid);
    ret = m_valid && en;
    if (ret) m_count = m_count + 32'd1;
    if (acc) begin
      m_valid = 1'b1; m_rd = in_rd; m_we = in_reg_write;
      if (in_load) ref_load(in_result, in_funct3, in_addr_lo, d, e);
      else begin d = in_result; e = 1'b0; end
      m_wd = d; m_err = e;
    end else if (ret) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic drive(input bit v, input logic [4:0] rd, input logic [31:0] res, input bit ld,
                       input logic [2:0] f3, input logic [1:0] lo, input bit rw);
    in_valid = v; in_rd = rd; in_result = res; in_load = ld;
    in_funct3 = f3; in_addr_lo = lo; in_reg_write = rw;
  endtask

  task automatic test_reset();
    rstn = 1'b0; en = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 2'd0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (A3 !== 5'd0) begin failures++; $display("FAIL reset_a3 got=%0h exp=0", A3); end
    checks++; if (WD3 !== 32'd0) begin failures++; $display("FAIL reset_wd3 got=%0h exp=0", WD3); end
    checks++; if (WE3 !== 1'b0 || fwd_valid !== 1'b0) begin failures++; $display("FAIL reset_we3 got=%0b/%0b exp=0/0", WE3, fwd_valid); end
    checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL reset_load_err got=%0b exp=0", load_err); end
    checks++; if (retire_count !== 32'd0) begin failures++; $display("FAIL reset_count got=%0h exp=0", retire_count); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    #3 rstn = 1'b1;
  endtask

  task automatic test_basic();
    drive(1'b1, 5'd5, 32'h1234, 1'b0, 3'd0, 2'd0, 1'b1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 2'd0, 1'b0);
    checks++; if (A3 !== 5'd5 || fwd_rd !== 5'd5) begin failures++; $display("FAIL basic_a3 got=%0h/%0h exp=5", A3, fwd_rd); end
    checks++; if (WD3 !== 32'h1234 || fwd_data !== 32'h1234) begin failures++; $display("FAIL basic_wd3 got=%0h/%0h exp=1234", WD3, fwd_data); end
    checks++; if (WE3 !== 1'b1 || fwd_valid !== 1'b1) begin failures++; $display("FAIL basic_we3 got=%0b/%0b exp=1/1", WE3, fwd_valid); end
    checks++; if (retire_count !== 32'd0) begin failures++; $display("FAIL basic_count0 got=%0h exp=0", retire_count); end
    tick();
    checks++; if (retire_count !== 32'd1) begin failures++; $display("FAIL basic_count1 got=%0h exp=1", retire_count); end
    checks++; if (WE3 !== 1'b0) begin failures++; $display("FAIL basic_we3_after got=%0b exp=0", WE3); end
  endtask

  task automatic test_load_format();
    logic [2:0]  f3s  [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
    logic [1:0]  los  [4] = '{2'd3, 2'd1, 2'd2, 2'd0};
    logic [31:0] exps [4] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF, 32'h0000_7F01};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'd10, 32'h80FF_7F01, 1'b1, f3s[i], los[i], 1'b1);
      tick();
      checks++; if (WD3 !== exps[i]) begin failures++; $display("FAIL load_fmt%0d_wd3 got=%0h exp=%0h", i, WD3, exps[i]); end
      checks++; if (WD3 !== m_wd) begin failures++; $display("FAIL load_fmt%0d_model got=%0h exp=%0h", i, WD3, m_wd); end
      checks++; if (WE3 !== 1'b1 || load_err !== 1'b0) begin failures++; $display("FAIL load_fmt%0d_we got=%0b/%0b exp=1/0", i, WE3, load_err); end
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 2'd0, 1'b0);
    tick();
  endtask

  task automatic test_load_err();
    logic [31:0] c0;
    c0 = m_count;
    drive(1'b1, 5'd7, 32'h80FF_7F01, 1'b1, 3'd2, 2'd2, 1'b1);
    tick();
    checks++; if (load_err !== 1'b1 || WE3 !== 1'b0 || fwd_valid !== 1'b0) begin failures++; $display("FAIL lw_misalign got=err%0b/we%0b/fv%0b exp=1/0/0", load_err, WE3, fwd_valid); end
    checks++; if (WD3 !== 32'h80FF_7F01) begin failures++; $display("FAIL lw_misalign_wd3 got=%0h exp=80ff7f01", WD3); end
    drive(1'b1, 5'd8, 32'h0000_00AA, 1'b1, 3'd3, 2'd0, 1'b1);
    tick();
    checks++; if (load_err !== 1'b1 || WE3 !== 1'b0) begin failures++; $display("FAIL f3_011 got=err%0b/we%0b exp=1/0", load_err, WE3); end
    checks++; if (retire_count !== c0 + 32'd1) begin failures++; $display("FAIL err_count1 got=%0h exp=%0h", retire_count, c0 + 32'd1); end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 2'd0, 1'b0);
    tick();
    checks++; if (retire_count !== c0 + 32'd2) begin failures++; $display("FAIL err_count2 got=%0h exp=%0h", retire_count, c0 + 32'd2); end
    checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL err_cleared got=%0b exp=0", load_err); end
  endtask

  task automatic test_x0();
    logic [31:0] c0;
    c0 = m_count;
    drive(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 3'd0, 2'd0, 1'b1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 2'd0, 1'b0);
    checks++; if (WE3 !== 1'b0 || fwd_valid !== 1'b0) begin failures++; $display("FAIL x0_we3 got=%0b/%0b exp=0/0", WE3, fwd_valid); end
    tick();
    checks++; if (retire_count !== c0 + 32'd1) begin failures++; $display("FAIL x0_count got=%0h exp=%0h", retire_count, c0 + 32'd1); end
  endtask

  task automatic test_hold();
    logic [31:0] c0;
    drive(1'b1, 5'd12, 32'hCAFE_0001, 1'b0, 3'd0, 2'd0, 1'b1);
    tick();
    c0 = m_count;
    en = 1'b0;
    drive(1'b1, 5'd13, 32'hCAFE_0002, 1'b0, 3'd0, 2'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL hold%0d_ready got=%0b exp=0", i, in_ready); end
      tick();
      checks++; if (A3 !== 5'd12 || WD3 !== 32'hCAFE_0001 || WE3 !== 1'b1) begin failures++; $display("FAIL hold%0d_stable got=%0h/%0h/%0b exp=c/cafe0001/1", i, A3, WD3, WE3); end
      checks++; if (retire_count !== c0) begin failures++; $display("FAIL hold%0d_count got=%0h exp=%0h", i, retire_count, c0); end
    end
    en = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL hold_release_ready got=%0b exp=1", in_ready); end
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 2'd0, 1'b0);
    checks++; if (A3 !== 5'd13 || WD3 !== 32'hCAFE_0002 || WE3 !== 1'b1) begin failures++; $display("FAIL back_to_back got=%0h/%0h/%0b exp=d/cafe0002/1", A3, WD3, WE3); end
    checks++; if (retire_count !== c0 + 32'd1) begin failures++; $display("FAIL back_to_back_count got=%0h exp=%0h", retire_count, c0 + 32'd1); end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      en = ($urandom_range(0, 3) != 0);
      drive(($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)), $urandom(),
            ($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 4) != 0));
      #1;
      checks++; if (in_ready !== (en || !m_valid)) begin failures++; $display("FAIL rnd%0d_ready got=%0b exp=%0b", i, in_ready, (en || !m_valid)); end
      tick();
      checks++; if (WE3 !== exp_we() || fwd_valid !== exp_we()) begin failures++; $display("FAIL rnd%0d_we got=%0b/%0b exp=%0b", i, WE3, fwd_valid, exp_we()); end
      checks++; if (load_err !== exp_err()) begin failures++; $display("FAIL rnd%0d_err got=%0b exp=%0b", i, load_err, exp_err()); end
      checks++; if (retire_count !== m_count) begin failures++; $display("FAIL rnd%0d_count got=%0h exp=%0h", i, retire_count, m_count); end
      if (m_valid) begin
        checks++; if (A3 !== m_rd || fwd_rd !== m_rd) begin failures++; $display("FAIL rnd%0d_a3 got=%0h/%0h exp=%0h", i, A3, fwd_rd, m_rd); end
        checks++; if (WD3 !== m_wd || fwd_data !== m_wd) begin failures++; $display("FAIL rnd%0d_wd3 got=%0h/%0h exp=%0h", i, WD3, fwd_data, m_wd); end
      end
    end
    en = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 2'd0, 1'b0);
    tick();
  endtask

  task automatic test_async_reset();
    drive(1'b1, 5'd9, 32'h5555_AAAA, 1'b0, 3'd0, 2'd0, 1'b1);
    tick();
    en = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 2'd0, 1'b0);
    checks++; if (WE3 !== 1'b1 || retire_count === 32'd0) begin failures++; $display("FAIL areset_pre got=we%0b/cnt%0h exp=1/nonzero", WE3, retire_count); end
    #2 rstn = 1'b0;
    #1;
    model_reset();
    checks++; if (WE3 !== 1'b0 || fwd_valid !== 1'b0) begin failures++; $display("FAIL areset_we3 got=%0b/%0b exp=0/0", WE3, fwd_valid); end
    checks++; if (retire_count !== 32'd0) begin failures++; $display("FAIL areset_count got=%0h exp=0", retire_count); end
    checks++; if (A3 !== 5'd0 || WD3 !== 32'd0) begin failures++; $display("FAIL areset_a3_wd3 got=%0h/%0h exp=0/0", A3, WD3); end
    #2 rstn = 1'b1;
    en = 1'b1;
  endtask

  task automatic test_wrap();
    tick();
    force dut.retire_count_r = 32'hFFFF_FFFF;
    #1;
    release dut.retire_count_r;
    m_count = 32'hFFFF_FFFF;
    checks++; if (retire_count !== m_count) begin failures++; $display("FAIL wrap_preload got=%0h exp=ffffffff", retire_count); end
    drive(1'b1, 5'd3, 32'h0000_0042, 1'b0, 3'd0, 2'd0, 1'b1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 2'd0, 1'b0);
    checks++; if (retire_count !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_hold got=%0h exp=ffffffff", retire_count); end
    tick();
    checks++; if (retire_count !== 32'd0 || retire_count !== m_count) begin failures++; $display("FAIL wrap_zero got=%0h exp=0", retire_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_load_format();
    test_load_err();
    test_x0();
    test_hold();
    test_random();
    test_async_reset();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
